// File: rtl/hash_pkg.sv
// hash_pkg
// Shared definitions for the hash output path.
//   HASH_IO_WIDTH : default stream/RAM word width in bits.
//   HW_*          : state encoding of hash_out_mem_writer.
//   CLOG2         : ceiling log2, used for address and counter widths.
package hash_pkg;

  localparam int HASH_IO_WIDTH = 32;

  localparam logic [1:0] HW_IDLE  = 2'd0;
  localparam logic [1:0] HW_WRITE = 2'd1;
  localparam logic [1:0] HW_FORCE = 2'd2;
  localparam logic [1:0] HW_DONE  = 2'd3;

  // Ceiling log2; CLOG2(1) is 0, CLOG2(16) is 4, CLOG2(17) is 5.
  function automatic int CLOG2(input longint value);
    int     result;
    longint v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hash_tail_mask.sv
// hash_tail_mask
// Combinational mask generator for the last, partially filled digest word.
// Bits below 'rem' are kept and the rest are cleared. A remainder of zero
// means the word is full, so every bit is kept.
// Ports:
//   rem  : number of valid bits in the last word (0 = full word)
//   mask : per-bit keep mask
module hash_tail_mask
  import hash_pkg::*;
#(
  parameter int IO_WIDTH = HASH_IO_WIDTH
) (
  input  logic [CLOG2(IO_WIDTH)-1:0] rem,
  output logic [IO_WIDTH-1:0]        mask
);

  always_comb begin
    mask = '1;
    for (int i = 0; i < IO_WIDTH; i++) begin
      if ((rem != '0) && (i >= int'(rem))) begin
        mask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hash_out_mem_writer.sv
// hash_out_mem_writer
// Drains the SHAKE digest stream into a word-addressed RAM. Writes
// ceil(length/IO_WIDTH) words to consecutive addresses (wrapping modulo the
// RAM depth), then asks keccak_top to stop squeezing and pulses done.
//
// Optional feature macro: HASH_WR_ZERO_PAD_EN
//   defined   : unused tail bits of the last partial word are written as 0
//   undefined : the last word is written exactly as received
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_start           : one-cycle start, only honoured in IDLE
//   i_output_length   : digest length in bits, captured on start
//   i_data_in / i_data_in_valid / o_data_in_ready : digest word stream
//   o_addr / o_wr_en / o_data_out : registered RAM write port
//   o_force_done / i_force_done_ack : squeeze-terminate handshake
//   o_busy            : high outside IDLE
//   o_done            : one-cycle completion pulse
module hash_out_mem_writer
  import hash_pkg::*;
#(
  parameter int IO_WIDTH      = HASH_IO_WIDTH,
  parameter int MAX_RAM_DEPTH = 16,
  parameter int MAX_OUT_SIZE  = 8388608
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [IO_WIDTH-1:0]              i_output_length,
  input  logic [IO_WIDTH-1:0]              i_data_in,
  input  logic                             i_data_in_valid,
  output logic                             o_data_in_ready,
  output logic [CLOG2(MAX_RAM_DEPTH)-1:0]  o_addr,
  output logic                             o_wr_en,
  output logic [IO_WIDTH-1:0]              o_data_out,
  output logic                             o_force_done,
  input  logic                             i_force_done_ack,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int AW = CLOG2(MAX_RAM_DEPTH);
  localparam int LW = CLOG2(IO_WIDTH);
  localparam int CW = CLOG2(MAX_OUT_SIZE / IO_WIDTH) + 1;

  logic [1:0]          state;
  logic [CW-1:0]       count;
  logic [CW-1:0]       words;
  logic [CW-1:0]       count_next;
  logic [IO_WIDTH-1:0] words_full;
  logic                last_beat;
  logic                beat;
  logic [IO_WIDTH-1:0] wr_word;

  // Word count is the whole-word part of the length plus one for any
  // leftover bits; computed straight from the input so it is ready at start.
  assign words_full = (i_output_length >> LW) + IO_WIDTH'(|i_output_length[LW-1:0]);

  assign count_next = count + CW'(1);
  assign last_beat  = (count_next == words);
  assign beat       = (state == HW_WRITE) && i_data_in_valid;

  assign o_data_in_ready = (state == HW_WRITE);
  assign o_busy          = (state != HW_IDLE);

`ifdef HASH_WR_ZERO_PAD_EN
  logic [LW-1:0]       rem;
  logic [IO_WIDTH-1:0] tail_mask;

  // The remainder only matters for the final word of the digest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= '0;
    end else if ((state == HW_IDLE) && i_start) begin
      rem <= i_output_length[LW-1:0];
    end
  end

  hash_tail_mask #(
    .IO_WIDTH(IO_WIDTH)
  ) u_tail_mask (
    .rem (rem),
    .mask(tail_mask)
  );

  assign wr_word = last_beat ? (i_data_in & tail_mask) : i_data_in;
`else
  assign wr_word = i_data_in;
`endif

  // Main controller. The RAM port and the handshake outputs are registered
  // here; write enable and done default low so they only pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= HW_IDLE;
      count        <= '0;
      words        <= '0;
      o_addr       <= '0;
      o_wr_en      <= 1'b0;
      o_data_out   <= '0;
      o_force_done <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        HW_IDLE: begin
          if (i_start) begin
            words  <= words_full[CW-1:0];
            count  <= '0;
            o_addr <= '0;
            if (words_full == '0) begin
              state        <= HW_FORCE;
              o_force_done <= 1'b1;
            end else begin
              state <= HW_WRITE;
            end
          end
        end
        HW_WRITE: begin
          if (beat) begin
            o_wr_en    <= 1'b1;
            o_addr     <= count[AW-1:0];
            o_data_out <= wr_word;
            count      <= count_next;
            if (last_beat) begin
              state        <= HW_FORCE;
              o_force_done <= 1'b1;
            end
          end
        end
        HW_FORCE: begin
          if (i_force_done_ack) begin
            o_force_done <= 1'b0;
            o_done       <= 1'b1;
            state        <= HW_DONE;
          end
        end
        HW_DONE: begin
          state <= HW_IDLE;
        end
        default: begin
          state <= HW_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_out_mem_writer.sv
// tb_hash_out_mem_writer
// Self-checking bench for hash_out_mem_writer: a table of directed
// transactions with hand-computed results, a reset-mid-transfer sequence,
// and randomized transactions checked against a list-based model of the
// expected RAM writes. Honours HASH_WR_ZERO_PAD_EN like the design.
module tb_hash_out_mem_writer;

  localparam int IO_WIDTH = 32;
  localparam int DEPTH    = 16;
`ifdef HASH_WR_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [31:0]   i_output_length = '0;
  logic [31:0]   i_data_in = '0;
  logic          i_data_in_valid = 1'b0;
  logic          o_data_in_ready;
  logic [3:0]    o_addr;
  logic          o_wr_en;
  logic [31:0]   o_data_out;
  logic          o_force_done;
  logic          i_force_done_ack = 1'b0;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  hash_out_mem_writer #(
    .IO_WIDTH(IO_WIDTH),
    .MAX_RAM_DEPTH(DEPTH),
    .MAX_OUT_SIZE(8388608)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_output_length(i_output_length),
    .i_data_in(i_data_in),
    .i_data_in_valid(i_data_in_valid),
    .o_data_in_ready(o_data_in_ready),
    .o_addr(o_addr),
    .o_wr_en(o_wr_en),
    .o_data_out(o_data_out),
    .o_force_done(o_force_done),
    .i_force_done_ack(i_force_done_ack),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0;
  int          force_cycles = 0;
  bit          mon_en = 1'b0;

  // Observe the RAM port and handshake outputs away from the active edge.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (o_wr_en) begin
        wr_addr_q.push_back(32'(o_addr));
        wr_data_q.push_back(o_data_out);
      end
      if (o_done) done_cnt++;
      if (o_force_done) force_cycles++;
    end
  end

  // Roughly 90k cycles; only reached if something hangs.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] word_src(input int kind, input int i);
    logic [31:0] v;
    if (kind == 1) v = (i == 0) ? 32'hDEADBEEF : 32'hCAFEBABE;
    else v = 32'h11111111 * 32'(i + 1);
    return v;
  endfunction

  // One complete transfer. kind: 0 counting words, 1 DEADBEEF/CAFEBABE,
  // 2 random. vmode: 0 continuous valid, 1 every other cycle, 2 random.
  // exp_words < 0 skips the hand-computed table checks.
  task automatic apply_stimulus(input int tag, input int len, input int kind, input int vmode,
                                input int ack_delay, input bit poke, input int exp_words,
                                input logic [31:0] exp_last);
    logic [31:0] src[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_addr[$];
    int n, rem, idx, cyc;
    bit v, ready_ok;
    logic [31:0] d;

    n   = (len + 31) / 32;
    rem = len % 32;
    for (int i = 0; i < n; i++) begin
      d = (kind == 2) ? $urandom : word_src(kind, i);
      src.push_back(d);
      if (PAD && (i == n - 1) && (rem != 0)) d = d & ((32'h1 << rem) - 32'h1);
      exp_data.push_back(d);
      exp_addr.push_back(32'(i % DEPTH));
    end

    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    force_cycles = 0;
    mon_en = 1'b1;

    i_output_length = 32'(len);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_output_length = $urandom;
    check_output($sformatf("t%0d busy_after_start", tag), 32'(o_busy), 32'd1);

    idx = 0;
    cyc = 0;
    ready_ok = 1'b1;
    while ((idx < n) && (cyc < 2000)) begin
      case (vmode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      i_data_in = v ? src[idx] : $urandom;
      i_data_in_valid = v;
      if (o_data_in_ready !== 1'b1) ready_ok = 1'b0;
      @(posedge clk); #1;
      if (v) idx++;
      cyc++;
    end
    i_data_in_valid = 1'b0;
    i_data_in = $urandom;
    check_output($sformatf("t%0d beats_accepted", tag), 32'(idx), 32'(n));
    check_output($sformatf("t%0d ready_in_write", tag), 32'(ready_ok), 32'd1);
    check_output($sformatf("t%0d force_rise", tag), 32'(o_force_done), 32'd1);
    check_output($sformatf("t%0d ready_low_force", tag), 32'(o_data_in_ready), 32'd0);

    for (int k = 0; k < ack_delay; k++) begin
      i_start = poke && (k == 0);
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_force_done_ack = 1'b1;
    @(posedge clk); #1;
    i_force_done_ack = 1'b0;
    check_output($sformatf("t%0d done_after_ack", tag), 32'(o_done), 32'd1);
    check_output($sformatf("t%0d force_dropped", tag), 32'(o_force_done), 32'd0);
    @(posedge clk); #1;
    check_output($sformatf("t%0d done_one_cycle", tag), 32'(o_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output($sformatf("t%0d idle_after", tag), 32'(o_busy), 32'd0);
    check_output($sformatf("t%0d force_cycles", tag), 32'(force_cycles), 32'(ack_delay + 1));
    check_output($sformatf("t%0d done_count", tag), 32'(done_cnt), 32'd1);

    check_output($sformatf("t%0d write_count", tag), 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; (i < n) && (i < wr_addr_q.size()); i++) begin
      check_output($sformatf("t%0d addr[%0d]", tag, i), wr_addr_q[i], exp_addr[i]);
      check_output($sformatf("t%0d data[%0d]", tag, i), wr_data_q[i], exp_data[i]);
    end
    if (exp_words >= 0) begin
      check_output($sformatf("t%0d tbl_words", tag), 32'(wr_data_q.size()), 32'(exp_words));
      if ((exp_words > 0) && (wr_data_q.size() > 0))
        check_output($sformatf("t%0d tbl_last", tag), wr_data_q[wr_data_q.size() - 1], exp_last);
    end
    mon_en = 1'b0;
  endtask

  typedef struct {
    int          len;
    int          kind;
    int          vmode;
    int          ack_delay;
    bit          poke;
    int          exp_words;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{256, 0, 0, 1, 1'b0, 8,  32'h88888888});
    vecs.push_back('{40,  1, 0, 1, 1'b0, 2,  PAD ? 32'h000000BE : 32'hCAFEBABE});
    vecs.push_back('{128, 0, 1, 1, 1'b0, 4,  32'h44444444});
    vecs.push_back('{0,   2, 0, 1, 1'b0, 0,  32'h00000000});
    vecs.push_back('{96,  0, 0, 5, 1'b1, 3,  32'h33333333});
    vecs.push_back('{33,  0, 0, 0, 1'b0, 2,  PAD ? 32'h00000000 : 32'h22222222});
    vecs.push_back('{1,   0, 1, 2, 1'b0, 1,  PAD ? 32'h00000001 : 32'h11111111});
    vecs.push_back('{600, 0, 2, 0, 1'b0, 19, PAD ? 32'h00444443 : 32'h44444443});
    vecs.push_back('{31,  0, 2, 3, 1'b0, 1,  32'h11111111});

    #2;
    rst = 1'b0;
    #1;
    check_output("reset ready", 32'(o_data_in_ready), 32'd0);
    check_output("reset addr", 32'(o_addr), 32'd0);
    check_output("reset wr_en", 32'(o_wr_en), 32'd0);
    check_output("reset data", o_data_out, 32'd0);
    check_output("reset force", 32'(o_force_done), 32'd0);
    check_output("reset busy", 32'(o_busy), 32'd0);
    check_output("reset done", 32'(o_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < vecs.size(); t++) begin
      apply_stimulus(t, vecs[t].len, vecs[t].kind, vecs[t].vmode, vecs[t].ack_delay,
                     vecs[t].poke, vecs[t].exp_words, vecs[t].exp_last);
      @(posedge clk); #1;
    end

    // Reset in the middle of a transfer: everything clears at once and no
    // done pulse follows.
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    mon_en = 1'b1;
    i_output_length = 32'd256;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_data_in = $urandom;
      i_data_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    #1;
    i_data_in_valid = 1'b0;
    check_output("midrst ready", 32'(o_data_in_ready), 32'd0);
    check_output("midrst addr", 32'(o_addr), 32'd0);
    check_output("midrst wr_en", 32'(o_wr_en), 32'd0);
    check_output("midrst data", o_data_out, 32'd0);
    check_output("midrst force", 32'(o_force_done), 32'd0);
    check_output("midrst busy", 32'(o_busy), 32'd0);
    check_output("midrst done", 32'(o_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("midrst no_done", 32'(done_cnt), 32'd0);
    check_output("midrst idle", 32'(o_busy), 32'd0);
    mon_en = 1'b0;
    apply_stimulus(100, 64, 0, 0, 1, 1'b0, 2, 32'h22222222);

    for (int t = 0; t < 40; t++) begin
      apply_stimulus(200 + t, int'($urandom_range(0, 700)), 2, 2, int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), -1, 32'h0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/hash_out_mem_writer.md
# hash_out_mem_writer

Drains the SHAKE digest stream produced by `hash_mem_interface` into a word-addressed RAM, the write-side counterpart of that block's RAM-read path. It accepts 32-bit digest words on a valid/ready handshake, writes exactly `ceil(i_output_length/IO_WIDTH)` words to consecutive addresses, and zero-masks the unused tail of the last word. It then force-terminates the squeeze in `keccak_top` and pulses done.

## Interface
- `IO_WIDTH`, 32: stream and RAM word width in bits; multiple of 8.
- `MAX_RAM_DEPTH`, 16: destination RAM depth in words; sets `o_addr` width to `CLOG2(MAX_RAM_DEPTH)`.
- `MAX_OUT_SIZE`, 8_388_608: maximum digest length in bits; sets the word counter width to `CLOG2(MAX_OUT_SIZE/IO_WIDTH)+1`.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  one-cycle start; sampled only in IDLE.
- `i_output_length`  in  IO_WIDTH  digest length in bits; captured on start.
- `i_data_in`  in  IO_WIDTH  digest word, first byte in bits [7:0].
- `i_data_in_valid`  in  1  stream valid.
- `o_data_in_ready`  out  1  stream ready.
- `o_addr`  out  CLOG2(MAX_RAM_DEPTH)  RAM write address.
- `o_wr_en`  out  1  RAM write enable.
- `o_data_out`  out  IO_WIDTH  RAM write data.
- `o_force_done`  out  1  squeeze-terminate request to `keccak_top`.
- `i_force_done_ack`  in  1  acknowledge from `keccak_top`.
- `o_busy`  out  1  high outside IDLE.
- `o_done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WRITE, FORCE, DONE.
- IDLE: on `i_start`, capture `len = i_output_length`. Compute `words = len[IO_WIDTH-1:CLOG2(IO_WIDTH)] + (len[CLOG2(IO_WIDTH)-1:0] != 0)` and `rem = len mod IO_WIDTH`. Clear the word counter and address. Go to WRITE, or to FORCE when `words == 0`.
- WRITE: `o_data_in_ready = 1`. Each beat with valid and ready does the following:
  - register `o_wr_en = 1`, `o_addr = count` truncated to address width, and the data word;
  - increment count.
- On the beat where `count == words-1`, go to FORCE.
- Tail masking: on the final beat with `rem != 0`, bits `[IO_WIDTH-1:rem]` of the written word are forced to 0.
- Address wrap: `o_addr` is `count` modulo `MAX_RAM_DEPTH`. Overflow writes wrap to address 0 and are not flagged.
- FORCE: hold `o_force_done = 1`. On `i_force_done_ack = 1`, drop it and go to DONE.
- DONE: `o_done = 1` for one cycle, then IDLE.
- `i_start` outside IDLE is ignored.
- Beats outside WRITE are not accepted, because ready is low.
- `i_output_length` changes after start have no effect.
- Asynchronous reset mid-operation:
  - all state returns to IDLE immediately;
  - any pending force request is dropped;
  - no done pulse is produced.

## Timing
- Reset values: `o_data_in_ready = 0`, `o_addr = 0`, `o_wr_en = 0`, `o_data_out = 0`, `o_force_done = 0`, `o_busy = 0`, `o_done = 0`.
- `o_data_in_ready` and `o_busy` decode directly from state. All other outputs are registered.
- RAM write lands one cycle after the accepted beat. Full throughput is one word per cycle, with no bubbles while valid stays high.
- `i_start` to first ready: 1 cycle.
- Last beat to `o_force_done` high: 1 cycle.
- Ack to `o_done`: 1 cycle. DONE to IDLE: 1 cycle.
- Ack asserted in the same cycle `o_force_done` rises is honoured.

## Configuration
- `HASH_WR_ZERO_PAD_EN` defined: tail bits of the last partial word are zeroed as described above.
- Undefined: the last word is written exactly as received. `rem` logic is removed, and word count and length semantics are unchanged.

## Structure
- Shared package `hash_pkg`:
  - state encoding constants `HW_IDLE`, `HW_WRITE`, `HW_FORCE`, `HW_DONE`;
  - `IO_WIDTH` default;
  - `CLOG2` include.
- One natural sub-module, `hash_tail_mask`: combinational; maps `rem` to the mask word and is instantiated only under `HASH_WR_ZERO_PAD_EN`.

## Test plan
- `len = 256`, continuous valid, words `0x11111111..0x88888888`, ack 1 cycle after force -> 8 writes to addr 0..7, data unchanged, `o_done` pulse 2 cycles after last write.
- `len = 40`, words `0xDEADBEEF`, `0xCAFEBABE` -> addr 1 written as `0x000000BE` with pad enabled, `0xCAFEBABE` without.
- `len = 128`, valid toggling every other cycle -> exactly 4 writes at addr 0..3, no duplicates, ready stays high throughout WRITE.
- `len = 0` -> no writes, `o_force_done` in the cycle after start, `o_done` after ack.
- `len = 96`, ack delayed 5 cycles -> `o_force_done` held 6 cycles, single `o_done`; a second `i_start` during FORCE is ignored.
- `len = 256`, `rst` low after 3 beats -> outputs at reset values immediately, no `o_done`; a subsequent start restarts writes at addr 0.
